// File: rtl/ieee488_host_port.sv
// Controller-side IEEE-488 byte engine: talker, one-entry listener, IFC.
// Define IEEE488_HOST_TIMEOUT_EN to abort stalled talker waits.
module ieee488_host_port #(
  parameter int TIMEOUT   = 64,
  parameter int SETTLE    = 2,
  parameter int IFC_TICKS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] tx_data,
  input  logic       tx_eoi,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       atn_req,
  input  logic       listen_en,
  output logic [7:0] rx_data,
  output logic       rx_eoi,
  output logic       rx_valid,
  input  logic       rx_ack,
  input  logic       ifc_pulse,
  output logic       st_timeout,
  output logic       st_nodev,
  output logic       busy,
  input  logic [7:0] ieee_data_i,
  output logic [7:0] ieee_data_o,
  output logic       ieee_atn_o,
  output logic       ieee_ifc_o,
  input  logic       ieee_srq_i,
  input  logic       ieee_dav_i,
  output logic       ieee_dav_o,
  input  logic       ieee_eoi_i,
  output logic       ieee_eoi_o,
  input  logic       ieee_nrfd_i,
  output logic       ieee_nrfd_o,
  input  logic       ieee_ndac_i,
  output logic       ieee_ndac_o
);
  localparam int CW = 10;
  localparam int IW = $clog2(IFC_TICKS + 1);

  typedef enum logic [1:0] {
    T_IDLE, T_WAITRDY, T_SETTLE, T_WAITACC
  } t_state_e;
  typedef enum logic {L_READY, L_ACC} l_state_e;

  t_state_e      t_state, t_next;
  l_state_e      l_state, l_next;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ifc_cnt;
  logic          ifc_act;
  logic [7:0]    data_r, tx_byte;
  logic          dav_r, eoi_r, nrfd_r, ndac_r;
  logic          eoi_lat, atn_lat;
  logic          tx_fire, l_act, cap, drive;
  logic          set_nodev, set_tout, tmo_hit;
  logic          unused_srq;

  assign unused_srq = ieee_srq_i;

`ifdef IEEE488_HOST_TIMEOUT_EN
  assign tmo_hit = ce && (cnt == CW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign tx_ready = (t_state == T_IDLE) && !ifc_act;
  assign tx_fire  = tx_valid && tx_ready && !ifc_pulse;
  assign l_act    = listen_en && (t_state == T_IDLE)
                    && !ifc_act && !ifc_pulse;
  assign drive    = (t_state == T_SETTLE)
                    || (t_state == T_WAITACC);
  assign busy     = (t_state != T_IDLE)
                    || (l_state != L_READY) || ifc_act;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= 8'hFF;
      dav_r  <= 1'b1;
      eoi_r  <= 1'b1;
      nrfd_r <= 1'b1;
      ndac_r <= 1'b1;
    end else begin
      data_r <= ieee_data_i;
      dav_r  <= ieee_dav_i;
      eoi_r  <= ieee_eoi_i;
      nrfd_r <= ieee_nrfd_i;
      ndac_r <= ieee_ndac_i;
    end
  end

  always_comb begin
    t_next    = t_state;
    set_nodev = 1'b0;
    set_tout  = 1'b0;
    unique case (t_state)
      T_IDLE:
        if (tx_fire) t_next = T_WAITRDY;
      T_WAITRDY:
        if (ce && cnt == '0 && nrfd_r && ndac_r) begin
          set_nodev = 1'b1;
          t_next    = T_IDLE;
        end else if (ce && nrfd_r) begin
          t_next = T_SETTLE;
        end else if (tmo_hit) begin
          set_tout = 1'b1;
          t_next   = T_IDLE;
        end
      T_SETTLE:
        if (ce && cnt == CW'(SETTLE - 1)) t_next = T_WAITACC;
      T_WAITACC:
        if (ce && ndac_r) begin
          t_next = T_IDLE;
        end else if (tmo_hit) begin
          set_tout = 1'b1;
          t_next   = T_IDLE;
        end
      default: t_next = T_IDLE;
    endcase
    if (ifc_pulse) begin
      t_next    = T_IDLE;
      set_nodev = 1'b0;
      set_tout  = 1'b0;
    end
  end

  always_comb begin
    l_next = l_state;
    cap    = 1'b0;
    if (!l_act) begin
      l_next = L_READY;
    end else if (ce) begin
      unique case (l_state)
        L_READY:
          if (!dav_r && !rx_valid) begin
            cap    = 1'b1;
            l_next = L_ACC;
          end
        L_ACC:
          if (dav_r) l_next = L_READY;
        default: l_next = L_READY;
      endcase
    end
  end

  // cnt restarts on every talker state change and saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_state <= T_IDLE;
      l_state <= L_READY;
      cnt     <= '0;
    end else begin
      t_state <= t_next;
      l_state <= l_next;
      if (t_next != t_state) cnt <= '0;
      else if (ce && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_byte    <= 8'h00;
      eoi_lat    <= 1'b0;
      atn_lat    <= 1'b0;
      st_nodev   <= 1'b0;
      st_timeout <= 1'b0;
      rx_data    <= 8'h00;
      rx_eoi     <= 1'b0;
      rx_valid   <= 1'b0;
    end else begin
      if (ifc_pulse) begin
        atn_lat <= 1'b0;
      end else if (tx_fire) begin
        tx_byte <= tx_data;
        eoi_lat <= tx_eoi;
        atn_lat <= atn_req;
      end
      if (tx_fire) begin
        st_nodev   <= 1'b0;
        st_timeout <= 1'b0;
      end else begin
        if (set_nodev) st_nodev <= 1'b1;
        if (set_tout) st_timeout <= 1'b1;
      end
      if (cap) begin
        rx_data  <= ~data_r;
        rx_eoi   <= ~eoi_r;
        rx_valid <= 1'b1;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifc_act <= 1'b0;
      ifc_cnt <= '0;
    end else if (ifc_pulse) begin
      ifc_act <= 1'b1;
      ifc_cnt <= IW'(IFC_TICKS);
    end else if (ifc_act && ce) begin
      if (ifc_cnt == IW'(1)) ifc_act <= 1'b0;
      ifc_cnt <= ifc_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ieee_data_o <= 8'hFF;
      ieee_eoi_o  <= 1'b1;
      ieee_dav_o  <= 1'b1;
      ieee_atn_o  <= 1'b1;
      ieee_ifc_o  <= 1'b1;
      ieee_nrfd_o <= 1'b1;
      ieee_ndac_o <= 1'b1;
    end else begin
      ieee_data_o <= drive ? ~tx_byte : 8'hFF;
      ieee_eoi_o  <= !(drive && eoi_lat);
      ieee_dav_o  <= (t_state != T_WAITACC);
      ieee_atn_o  <= !atn_lat;
      ieee_ifc_o  <= !ifc_act;
      ieee_nrfd_o <= l_act
                     ? (l_state == L_READY && !rx_valid)
                     : 1'b1;
      ieee_ndac_o <= l_act ? (l_state == L_ACC) : 1'b1;
    end
  end

endmodule

// File: tb/tb_ieee488_host_port.sv
// Directed bench for ieee488_host_port: talker, listener, IFC, reset.
// Talker timeout expectations follow IEEE488_HOST_TIMEOUT_EN.
module tb_ieee488_host_port;
  logic       clk = 1'b0;
  logic       reset, ce;
  logic [7:0] tx_data;
  logic       tx_eoi, tx_valid, tx_ready, atn_req, listen_en;
  logic [7:0] rx_data;
  logic       rx_eoi, rx_valid, rx_ack, ifc_pulse;
  logic       st_timeout, st_nodev, busy;
  logic [7:0] ieee_data_i, ieee_data_o;
  logic       ieee_atn_o, ieee_ifc_o, ieee_srq_i;
  logic       ieee_dav_i, ieee_dav_o, ieee_eoi_i, ieee_eoi_o;
  logic       ieee_nrfd_i, ieee_nrfd_o, ieee_ndac_i, ieee_ndac_o;

  logic [7:0] dev_data = 8'hFF;
  logic       dev_dav = 1'b1, dev_eoi = 1'b1;
  logic       dev_nrfd = 1'b1, dev_ndac = 1'b1;
  int         dev_mode, pmode = -1;
  int         hold, tk, tcnt, dav_low_cnt = 0;
  logic       got = 1'b0, dev_eoi_seen, dev_atn_seen;
  logic [7:0] dev_byte, dev_pre, last_data = 8'hFF;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ieee_srq_i  = 1'b1;
  assign ieee_data_i = ieee_data_o & dev_data;
  assign ieee_dav_i  = ieee_dav_o & dev_dav;
  assign ieee_eoi_i  = ieee_eoi_o & dev_eoi;
  assign ieee_nrfd_i = ieee_nrfd_o & dev_nrfd;
  assign ieee_ndac_i = ieee_ndac_o & dev_ndac;

  ieee488_host_port dut (
    .clk(clk), .reset(reset), .ce(ce),
    .tx_data(tx_data), .tx_eoi(tx_eoi),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .atn_req(atn_req), .listen_en(listen_en),
    .rx_data(rx_data), .rx_eoi(rx_eoi),
    .rx_valid(rx_valid), .rx_ack(rx_ack),
    .ifc_pulse(ifc_pulse),
    .st_timeout(st_timeout), .st_nodev(st_nodev),
    .busy(busy),
    .ieee_data_i(ieee_data_i), .ieee_data_o(ieee_data_o),
    .ieee_atn_o(ieee_atn_o), .ieee_ifc_o(ieee_ifc_o),
    .ieee_srq_i(ieee_srq_i),
    .ieee_dav_i(ieee_dav_i), .ieee_dav_o(ieee_dav_o),
    .ieee_eoi_i(ieee_eoi_i), .ieee_eoi_o(ieee_eoi_o),
    .ieee_nrfd_i(ieee_nrfd_i), .ieee_nrfd_o(ieee_nrfd_o),
    .ieee_ndac_i(ieee_ndac_i), .ieee_ndac_o(ieee_ndac_o)
  );

  // Device model: 0 absent, 1 slow listener, 2 stuck listener,
  // 3 talker sending 0x0D+EOI, 4 talker that never drops DAV.
  always @(negedge clk) begin
    if (!ieee_dav_o) dav_low_cnt++;
    if (dev_mode != pmode) begin
      pmode = dev_mode;
      dev_data = 8'hFF; dev_dav = 1'b1; dev_eoi = 1'b1;
      dev_nrfd = 1'b1; dev_ndac = 1'b1;
      hold = 5; got = 1'b0; tk = 0; tcnt = 0;
      if (dev_mode == 1) begin
        dev_nrfd = 1'b0; dev_ndac = 1'b0;
      end
      if (dev_mode == 2) dev_ndac = 1'b0;
    end else begin
      case (dev_mode)
        1: begin
          if (!got) begin
            if (hold > 0) begin
              if (!tx_ready) hold--;
            end else if (!ieee_dav_o) begin
              got = 1'b1;
              dev_byte = ieee_data_o;
              dev_pre = last_data;
              dev_eoi_seen = !ieee_eoi_o;
              dev_atn_seen = ieee_atn_o;
              dev_nrfd = 1'b0;
              dev_ndac = 1'b1;
            end else begin
              dev_nrfd = 1'b1;
            end
          end else if (ieee_dav_o) begin
            dev_ndac = 1'b0;
          end
        end
        3, 4: begin
          case (tk)
            0: if (ieee_nrfd_o && !ieee_ndac_o) begin
                 dev_data = ~8'h0D; dev_eoi = 1'b0;
                 tcnt = 2; tk = 1;
               end
            1: if (tcnt > 0) tcnt--;
               else begin dev_dav = 1'b0; tk = 2; end
            2: if (ieee_ndac_o && dev_mode == 3) begin
                 dev_dav = 1'b1; dev_data = 8'hFF;
                 dev_eoi = 1'b1; tk = 3;
               end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
    last_data = ieee_data_o;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic send(input logic [7:0] d,
                      input logic e, input logic a);
    tx_data = d; tx_eoi = e; atn_req = a; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  function automatic logic [11:0] flags();
    return {tx_ready, rx_valid, rx_eoi, st_timeout,
            st_nodev, busy, ieee_atn_o, ieee_ifc_o,
            ieee_dav_o, ieee_eoi_o, ieee_nrfd_o, ieee_ndac_o};
  endfunction

  initial begin
    int n;
    int dl;
    reset = 1'b1; ce = 1'b1; tx_data = 8'h00; tx_eoi = 1'b0;
    tx_valid = 1'b0; atn_req = 1'b0; listen_en = 1'b0;
    rx_ack = 1'b0; ifc_pulse = 1'b0; dev_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_flags", flags(), 12'h83F);
    chk("rst_data", ieee_data_o, 8'hFF);
    chk("rst_rxdata", rx_data, 8'h00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_flags", flags(), 12'h83F);

    // Slow listener, ATN byte 0x28
    dev_mode = 1;
    repeat (3) @(negedge clk);
    send(8'h28, 1'b0, 1'b1);
    chk("t1_accepted", tx_ready, 1'b0);
    n = 0;
    while (!tx_ready && n < 200) begin @(negedge clk); n++; end
    chk("t1_ready", tx_ready, 1'b1);
    chk("t1_got", got, 1'b1);
    chk("t1_data_dav", dev_byte, 8'hD7);
    chk("t1_data_pre", dev_pre, 8'hD7);
    chk("t1_atn_dav", dev_atn_seen, 1'b0);
    chk("t1_eoi_dav", dev_eoi_seen, 1'b0);
    repeat (2) @(negedge clk);
    chk("t1_atn_hold", ieee_atn_o, 1'b0);
    chk("t1_dav_rel", ieee_dav_o, 1'b1);
    chk("t1_data_rel", ieee_data_o, 8'hFF);
    chk("t1_nodev", st_nodev, 1'b0);

    // No device on the bus
    dev_mode = 0;
    repeat (3) @(negedge clk);
    dl = dav_low_cnt;
    send(8'h41, 1'b0, 1'b0);
    n = 0;
    while (!tx_ready && n < 50) begin @(negedge clk); n++; end
    chk("t2_ready", tx_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("t2_nodev", st_nodev, 1'b1);
    chk("t2_no_dav", dav_low_cnt - dl, 0);
    chk("t2_atn_rel", ieee_atn_o, 1'b1);

    // IFC on the same edge as a transfer drops the byte
    tx_data = 8'h55; atn_req = 1'b1;
    tx_valid = 1'b1; ifc_pulse = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; ifc_pulse = 1'b0; atn_req = 1'b0;
    @(negedge clk);
    chk("t2b_ifc", ieee_ifc_o, 1'b0);
    chk("t2b_txrdy", tx_ready, 1'b0);
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk("t2b_busy", busy, 1'b0);
    chk("t2b_kept_nodev", st_nodev, 1'b1);
    chk("t2b_no_dav", dav_low_cnt - dl, 0);

    // Device never releases NDAC
    dev_mode = 2;
    repeat (3) @(negedge clk);
    send(8'h5A, 1'b0, 1'b1);
    n = 0;
    while (ieee_dav_o && n < 50) begin @(negedge clk); n++; end
    chk("t3_dav", ieee_dav_o, 1'b0);
`ifdef IEEE488_HOST_TIMEOUT_EN
    n = 0;
    while (!ieee_dav_o && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("t3_tmo_len", (n >= 63 && n <= 65) ? 64 : n, 64);
    chk("t3_st_tmo", st_timeout, 1'b1);
    repeat (2) @(negedge clk);
    chk("t3_idle", busy, 1'b0);
    send(8'h5A, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
`else
    repeat (1000) @(negedge clk);
    chk("t3_wait_dav", ieee_dav_o, 1'b0);
    chk("t3_wait_busy", busy, 1'b1);
    chk("t3_no_tmo", st_timeout, 1'b0);
`endif

    // IFC mid T_WAITACC
    chk("t4_atn_pre", ieee_atn_o, 1'b0);
    chk("t4_dav_pre", ieee_dav_o, 1'b0);
    ifc_pulse = 1'b1;
    @(negedge clk);
    ifc_pulse = 1'b0;
    @(negedge clk);
    chk("t4_dav", ieee_dav_o, 1'b1);
    chk("t4_atn", ieee_atn_o, 1'b1);
    chk("t4_ifc", ieee_ifc_o, 1'b0);
    chk("t4_busy", busy, 1'b1);
    n = 0;
    while (!ieee_ifc_o && n < 500) begin @(negedge clk); n++; end
    chk("t4_ifc_len", n, 100);
    chk("t4_busy_end", busy, 1'b0);
    chk("t4_txrdy_end", tx_ready, 1'b1);
    chk("t4_data_rel", ieee_data_o, 8'hFF);

    // Listener receives 0x0D with EOI
    dev_mode = 0; atn_req = 1'b0;
    repeat (2) @(negedge clk);
    listen_en = 1'b1;
    repeat (3) @(negedge clk);
    dev_mode = 3;
    n = 0;
    while (!rx_valid && n < 100) begin @(negedge clk); n++; end
    chk("t5_valid", rx_valid, 1'b1);
    chk("t5_data", rx_data, 8'h0D);
    chk("t5_eoi", rx_eoi, 1'b1);
    repeat (10) @(negedge clk);
    chk("t5_talker_done", tk, 3);
    chk("t5_nrfd_hold", ieee_nrfd_o, 1'b0);
    chk("t5_ndac", ieee_ndac_o, 1'b0);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    chk("t5_ack", rx_valid, 1'b0);
    @(negedge clk);
    chk("t5_nrfd_rel", ieee_nrfd_o, 1'b1);
    chk("t5_data_kept", rx_data, 8'h0D);

    // Asynchronous reset while in L_ACC
    dev_mode = 4;
    n = 0;
    while (!ieee_ndac_o && n < 100) begin @(negedge clk); n++; end
    chk("t6_lacc_ndac", ieee_ndac_o, 1'b1);
    chk("t6_lacc_nrfd", ieee_nrfd_o, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t6_flags", flags(), 12'h83F);
    chk("t6_data", ieee_data_o, 8'hFF);
    chk("t6_rxdata", rx_data, 8'h00);
    @(negedge clk);
    dev_mode = 0; listen_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ieee488_host_port.md
# ieee488_host_port

Controller-side IEEE-488 byte engine: the PET end of the bus that the 2031-mode drive listens and talks on. It turns a host byte-stream handshake into the three-wire DAV/NRFD/NDAC protocol, with ATN and EOI framing, when talking. It captures bytes from a talking drive into a one-entry buffer when listening. It sits between the PET core's bus glue and the drive's `ieee_*` ports, and lets simulation or an alternate core drive the bus without the 6520/6522 firmware path.

## Interface
- `TIMEOUT`, 64: `ce` ticks a talker wait state may last before aborting (10..1023).
- `SETTLE`, 2: `ce` ticks data/EOI must be stable before DAV is asserted (1..15).
- `IFC_TICKS`, 100: `ce` ticks IFC is held asserted.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `ce` in 1: tick enable; all FSMs and counters advance only when `ce`=1.
- `tx_data` in 8: byte to send.
- `tx_eoi` in 1: assert EOI with this byte.
- `tx_valid` in 1, `tx_ready` out 1: valid/ready; a transfer occurs on a `clk` edge with both high.
- `atn_req` in 1: level; ATN state for subsequent bytes, sampled only in `T_IDLE`.
- `listen_en` in 1: enable the listener.
- `rx_data` out 8, `rx_eoi` out 1, `rx_valid` out 1: received byte.
- `rx_ack` in 1: pops the rx buffer.
- `ifc_pulse` in 1: request an interface clear.
- `st_timeout` out 1: sticky; last send aborted on timeout.
- `st_nodev` out 1: sticky; NRFD and NDAC were both released at send start.
- `busy` out 1: any FSM not idle.
- Bus, all lines electrical level, 1 = released, 0 = asserted, data active-low: `ieee_data_i/o` 8, `ieee_atn_o`, `ieee_ifc_o`, `ieee_srq_i`, `ieee_dav_i/o`, `ieee_eoi_i/o`, `ieee_nrfd_i/o`, `ieee_ndac_i/o`.

## Operation
- All bus inputs are registered once before use.
- **Talker FSM**
  - `T_IDLE`: `tx_ready`=1. On transfer:
    - latch byte, EOI and `atn_req`;
    - clear `st_timeout`/`st_nodev`;
    - release our NRFD/NDAC;
    - go to `T_WAITRDY`.
  - `T_WAITRDY`:
    - On the first tick, if NRFD=1 and NDAC=1: set `st_nodev` and go to `T_IDLE`.
    - Otherwise wait for NRFD=1, then drive `~data` and EOI and go to `T_SETTLE`.
  - `T_SETTLE`: after `SETTLE` ticks, assert DAV and go to `T_WAITACC`.
  - `T_WAITACC`: wait for NDAC=1, then release DAV, data and EOI and go to `T_IDLE`.
- ATN output is `~atn_latched` and holds between bytes until the next accepted byte changes it.
- Listener is active when `listen_en`=1 and the talker is in `T_IDLE`; otherwise NRFD/NDAC are released.
  - `L_READY`: NDAC asserted. NRFD is released only if `rx_valid`=0. When DAV=0, capture `~ieee_data_i` and `~ieee_eoi_i`, set `rx_valid`, assert NRFD, release NDAC, and go to `L_ACC`.
  - `L_ACC`: when DAV=1, assert NDAC and go to `L_READY`.
- `rx_ack` with `rx_valid`=1 clears `rx_valid` next cycle. `rx_data` and `rx_eoi` hold until the next capture.
- **IFC**: `ifc_pulse` in any state:
  - both FSMs go idle;
  - all lines are released except IFC, which is held for `IFC_TICKS`;
  - `busy`=1 meanwhile and `tx_valid` is not accepted;
  - `atn_latched` is cleared.
- SRQ is input-only and is not interpreted.

## Timing
- Reset values:
  - all `ieee_*_o` = 1 (data 8'hFF);
  - `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `rx_eoi`=0;
  - status outputs 0, `busy`=0.
- Bus outputs are registered and change 1 `clk` after the state change.
- Bus input to reaction latency is 2 `clk` plus the wait for `ce`.
- A send with a prompt listener takes at least SETTLE+3 ticks, from accept to the next `tx_ready`.
- `ifc_pulse` on the same edge as a tx transfer: IFC wins and the byte is dropped.
- `listen_en` falling mid-`L_ACC`: release NRFD/NDAC immediately. A captured byte is kept.
- A capture and `rx_ack` in the same cycle cannot both take effect, because NRFD blocks capture while `rx_valid`=1.
- Asynchronous `reset` mid-handshake releases all lines within the reset assertion.

## Configuration
- `IEEE488_HOST_TIMEOUT_EN` defined:
  - a `ce` counter runs in `T_WAITRDY` and `T_WAITACC`;
  - reaching `TIMEOUT` releases DAV, data and EOI, sets `st_timeout` and returns to `T_IDLE`.
- Undefined: talker waits indefinitely and `st_timeout` is tied 0.

## Test plan
- Model device holds NRFD=0 for 5 ticks, then accepts. Send 8'h28 with ATN → data lines 8'hD7 before DAV=0; ATN=0 persists after the byte; `tx_ready` returns.
- No device (NRFD=NDAC=1). Send 8'h41 → `st_nodev`=1; DAV never asserted.
- Device never releases NDAC, with the macro defined and TIMEOUT=64 → DAV released at tick 64±1; `st_timeout`=1. Without the macro the engine is still waiting at tick 1000.
- `listen_en`=1 and the model talker sends 8'h0D with EOI → `rx_data`=8'h0D, `rx_eoi`=1. NRFD stays 0 until `rx_ack`.
- Pulse `ifc_pulse` mid-`T_WAITACC` → IFC=0 for 100 ticks; DAV/ATN=1 within 2 clks; `busy` low afterwards.
- Assert `reset` during `L_ACC` → all outputs return to their reset values asynchronously.
